// File: rtl/ysyx_redirect_ctrl_if.sv
// rtl/ysyx_redirect_ctrl_if.sv - writeback/trap/IFU redirect bus for ysyx_redirect_ctrl
//
// Purpose: groups the writeback request, trap request and IFU redirect
// handshake signals of the redirect controller into one bundle.
// Modports:
//   slave  - the redirect controller (consumes requests, drives redirect/flush)
//   master - the surrounding pipeline (drives requests, consumes redirect/flush)
// Signals:
//   wb_valid, wb_change, wb_retire, wb_npc[XLEN]  writeback commit info
//   trap_valid, trap_vec[XLEN], trap_ack          trap request and accept pulse
//   ifu_ready, redir_valid, redir_pc[XLEN]        redirect handshake to the IFU
//   flush, busy                                   pipeline kill and commit stall

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_redirect_ctrl_if #(
  parameter int XLEN = `YSYX_XLEN
);
  logic            wb_valid;
  logic            wb_change;
  logic            wb_retire;
  logic [XLEN-1:0] wb_npc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            trap_ack;
  logic            ifu_ready;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
  logic            busy;

  modport slave (
    input  wb_valid, wb_change, wb_retire, wb_npc,
    input  trap_valid, trap_vec, ifu_ready,
    output trap_ack, redir_valid, redir_pc, flush, busy
  );

  modport master (
    output wb_valid, wb_change, wb_retire, wb_npc,
    output trap_valid, trap_vec, ifu_ready,
    input  trap_ack, redir_valid, redir_pc, flush, busy
  );
endinterface

// File: rtl/ysyx_redirect_ctrl.sv
// rtl/ysyx_redirect_ctrl.sv - commit-side redirect controller (flush then IFU redirect)
//
// Purpose: arbitrates branch-mispredict and trap redirect requests (trap wins),
// holds flush for FLUSH_CYCLES cycles, then offers the target PC to the IFU
// with a valid/ready handshake. busy is high whenever the FSM is not idle.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   bus (slave)      request inputs, trap_ack, redir_valid/redir_pc, flush, busy
//   perf_commit, perf_mispredict, perf_branch_ok, perf_trap
//                    32-bit event counters, present only when
//                    YSYX_REDIRECT_PERF_EN is defined
// Parameters: XLEN (PC width), FLUSH_CYCLES (1..15)
// Optional feature macro: YSYX_REDIRECT_PERF_EN

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_redirect_ctrl #(
  parameter int XLEN         = `YSYX_XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_redirect_ctrl_if.slave  bus
`ifdef YSYX_REDIRECT_PERF_EN
  ,
  output logic [31:0]          perf_commit,
  output logic [31:0]          perf_mispredict,
  output logic [31:0]          perf_branch_ok,
  output logic [31:0]          perf_trap
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            trap_ack_q, trap_ack_d;
  logic            br_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      redir_pc_q <= '0;
      trap_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
      trap_ack_q <= trap_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_pc_d = redir_pc_q;
    trap_ack_d = 1'b0;
    br_accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Trap takes priority; a same-cycle branch is killed by the flush anyway.
        if (bus.trap_valid) begin
          redir_pc_d = bus.trap_vec;
          trap_ack_d = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = S_FLUSH;
        end else if (bus.wb_valid && bus.wb_change) begin
          redir_pc_d = bus.wb_npc;
          br_accept  = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_REDIR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REDIR: begin
        if (bus.ifu_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs come only from registered state, no input-to-output paths.
  assign bus.flush       = (state_q == S_FLUSH);
  assign bus.redir_valid = (state_q == S_REDIR);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.redir_pc    = redir_pc_q;
  assign bus.trap_ack    = trap_ack_q;

`ifdef YSYX_REDIRECT_PERF_EN
  logic [31:0] perf_commit_q, perf_mispredict_q, perf_branch_ok_q, perf_trap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_commit_q     <= 32'd0;
      perf_mispredict_q <= 32'd0;
      perf_branch_ok_q  <= 32'd0;
      perf_trap_q       <= 32'd0;
    end else begin
      if (bus.wb_valid)                 perf_commit_q     <= perf_commit_q + 32'd1;
      if (br_accept)                    perf_mispredict_q <= perf_mispredict_q + 32'd1;
      if (bus.wb_valid && bus.wb_retire) perf_branch_ok_q <= perf_branch_ok_q + 32'd1;
      if (trap_ack_q)                   perf_trap_q       <= perf_trap_q + 32'd1;
    end
  end

  assign perf_commit     = perf_commit_q;
  assign perf_mispredict = perf_mispredict_q;
  assign perf_branch_ok  = perf_branch_ok_q;
  assign perf_trap       = perf_trap_q;
`else
  // wb_retire only feeds the performance counters.
  logic unused_retire;
  assign unused_retire = bus.wb_retire ^ br_accept;
`endif

endmodule

// File: tb/tb_ysyx_redirect_ctrl.sv
// tb/tb_ysyx_redirect_ctrl.sv - directed self-checking bench for ysyx_redirect_ctrl

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module tb_ysyx_redirect_ctrl;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  ysyx_redirect_ctrl_if #(.XLEN(32)) bus ();

`ifdef YSYX_REDIRECT_PERF_EN
  logic [31:0] perf_commit, perf_mispredict, perf_branch_ok, perf_trap;
`endif

  ysyx_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef YSYX_REDIRECT_PERF_EN
    ,
    .perf_commit     (perf_commit),
    .perf_mispredict (perf_mispredict),
    .perf_branch_ok  (perf_branch_ok),
    .perf_trap       (perf_trap)
`endif
  );

  // {flush, redir_valid, busy, trap_ack}
  logic [3:0] st;
  assign st = {bus.flush, bus.redir_valid, bus.busy, bus.trap_ack};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid   = 1'b0;
    bus.wb_change  = 1'b0;
    bus.wb_retire  = 1'b0;
    bus.wb_npc     = 32'h0;
    bus.trap_valid = 1'b0;
    bus.trap_vec   = 32'h0;
    bus.ifu_ready  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b expected %b", st, 4'b0000); end
    n_checks++; if (bus.redir_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.redir_pc, 32'h0); end
    reset = 1'b0;
    tick();
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_branch();
    bus.wb_valid = 1'b1; bus.wb_change = 1'b1; bus.wb_npc = 32'h8000_0100;
    tick();
    bus.wb_valid = 1'b0; bus.wb_change = 1'b0;
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL branch_flush1: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL branch_flush2: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b0110) begin n_fail++; $display("FAIL branch_redir: got %b expected %b", st, 4'b0110); end
    n_checks++; if (bus.redir_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL branch_pc: got %h expected %h", bus.redir_pc, 32'h8000_0100); end
    tick();
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL branch_idle: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_simultaneous();
    bus.wb_valid = 1'b1; bus.wb_change = 1'b1; bus.wb_npc = 32'h8000_0200;
    bus.trap_valid = 1'b1; bus.trap_vec = 32'h8000_0004;
    tick();
    bus.wb_valid = 1'b0; bus.wb_change = 1'b0; bus.trap_valid = 1'b0;
    n_checks++; if (st !== 4'b1011) begin n_fail++; $display("FAIL simul_ack: got %b expected %b", st, 4'b1011); end
    tick();
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL simul_ack_pulse: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b0110) begin n_fail++; $display("FAIL simul_redir: got %b expected %b", st, 4'b0110); end
    n_checks++; if (bus.redir_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL simul_pc: got %h expected %h", bus.redir_pc, 32'h8000_0004); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL simul_no_second: got %b expected %b", st, 4'b0000); end
    end
  endtask

  task automatic test_backpressure();
    bus.ifu_ready = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_change = 1'b1; bus.wb_npc = 32'h8000_0300;
    tick();
    bus.wb_valid = 1'b0; bus.wb_change = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.ifu_ready = 1'b1;
      n_checks++; if (st !== 4'b0110) begin n_fail++; $display("FAIL bp_valid_%0d: got %b expected %b", i, st, 4'b0110); end
      n_checks++; if (bus.redir_pc !== 32'h8000_0300) begin n_fail++; $display("FAIL bp_pc_%0d: got %h expected %h", i, bus.redir_pc, 32'h8000_0300); end
      tick();
    end
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL bp_idle: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_trap_in_flush();
    bus.wb_valid = 1'b1; bus.wb_change = 1'b1; bus.wb_npc = 32'h8000_0400;
    tick();
    bus.wb_valid = 1'b0; bus.wb_change = 1'b0;
    bus.trap_valid = 1'b1; bus.trap_vec = 32'h8000_0008;
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL tif_flush1: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL tif_flush2_noack: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b0110) begin n_fail++; $display("FAIL tif_redir1: got %b expected %b", st, 4'b0110); end
    n_checks++; if (bus.redir_pc !== 32'h8000_0400) begin n_fail++; $display("FAIL tif_pc1: got %h expected %h", bus.redir_pc, 32'h8000_0400); end
    tick();
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL tif_idle_gap: got %b expected %b", st, 4'b0000); end
    tick();
    bus.trap_valid = 1'b0;
    n_checks++; if (st !== 4'b1011) begin n_fail++; $display("FAIL tif_trap_ack: got %b expected %b", st, 4'b1011); end
    tick();
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL tif_flush_b: got %b expected %b", st, 4'b1010); end
    tick();
    n_checks++; if (st !== 4'b0110) begin n_fail++; $display("FAIL tif_redir2: got %b expected %b", st, 4'b0110); end
    n_checks++; if (bus.redir_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL tif_pc2: got %h expected %h", bus.redir_pc, 32'h8000_0008); end
    tick();
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL tif_idle_end: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_reset_in_flush();
    bus.wb_valid = 1'b1; bus.wb_change = 1'b1; bus.wb_npc = 32'h8000_0500;
    tick();
    bus.wb_valid = 1'b0; bus.wb_change = 1'b0;
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL rif_flush: got %b expected %b", st, 4'b1010); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (st !== 4'b0000) begin n_fail++; $display("FAIL rif_status: got %b expected %b", st, 4'b0000); end
    n_checks++; if (bus.redir_pc !== 32'h0) begin n_fail++; $display("FAIL rif_pc: got %h expected %h", bus.redir_pc, 32'h0); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.redir_valid !== 1'b0) begin n_fail++; $display("FAIL rif_no_redir_%0d: got %b expected %b", i, bus.redir_valid, 1'b0); end
    end
  endtask

`ifdef YSYX_REDIRECT_PERF_EN
  task automatic test_perf();
    // kind: 0 plain commit, 1 mispredict, 2 good branch
    int kinds [10] = '{1, 2, 0, 2, 1, 0, 2, 2, 1, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.wb_valid  = 1'b1;
      bus.wb_change = (kinds[i] == 1);
      bus.wb_retire = (kinds[i] == 2);
      bus.wb_npc    = 32'h8000_1000 + 32'(i);
      tick();
      bus.wb_valid = 1'b0; bus.wb_change = 1'b0; bus.wb_retire = 1'b0;
      if (kinds[i] == 1) begin
        tick(); tick(); tick();
      end
    end
    bus.trap_valid = 1'b1; bus.trap_vec = 32'h8000_0010;
    tick();
    bus.trap_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (perf_commit !== 32'd10) begin n_fail++; $display("FAIL perf_commit: got %0d expected %0d", perf_commit, 10); end
    n_checks++; if (perf_mispredict !== 32'd3) begin n_fail++; $display("FAIL perf_mispredict: got %0d expected %0d", perf_mispredict, 3); end
    n_checks++; if (perf_branch_ok !== 32'd4) begin n_fail++; $display("FAIL perf_branch_ok: got %0d expected %0d", perf_branch_ok, 4); end
    n_checks++; if (perf_trap !== 32'd1) begin n_fail++; $display("FAIL perf_trap: got %0d expected %0d", perf_trap, 1); end
    force dut.perf_commit_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_commit_q;
    bus.wb_valid = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    n_checks++; if (perf_commit !== 32'd0) begin n_fail++; $display("FAIL perf_wrap: got %h expected %h", perf_commit, 32'h0); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_branch();
    test_simultaneous();
    test_backpressure();
    test_trap_in_flush();
    test_reset_in_flush();
`ifdef YSYX_REDIRECT_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_redirect_ctrl.md
# ysyx_redirect_ctrl

Commit-side redirect controller between the writeback stage and the instruction fetch unit. It takes redirect requests from two sources: branch mispredictions reported at writeback, and trap/exception vectors from the CSR unit. It arbitrates between them, then sequences a fixed-length pipeline flush followed by a valid/ready redirect handshake to the IFU. While a redirect is in progress it holds commit stalled through `busy`.

## Interface
Parameters:
- `XLEN`, default `` `YSYX_XLEN ``: width of PC/vector datapath.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is held high; legal range 1..15.

Ports (reset is synchronous and active-high on `reset`; clock is `clock`):
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `wb_valid`  in  1  writeback commits an instruction this cycle
- `wb_change`  in  1  committed instruction mispredicted; redirect to `wb_npc` required (qualified by `wb_valid`)
- `wb_retire`  in  1  committed instruction is a correctly predicted branch (qualified by `wb_valid`)
- `wb_npc`  in  XLEN  correct next PC for a mispredicted branch
- `trap_valid`  in  1  trap redirect request; level, held by the source until `trap_ack`
- `trap_vec`  in  XLEN  trap target PC, stable while `trap_valid`
- `trap_ack`  out  1  one-cycle pulse: trap request accepted
- `ifu_ready`  in  1  IFU accepts redirect
- `redir_valid`  out  1  redirect offered to IFU
- `redir_pc`  out  XLEN  redirect target, stable while `redir_valid`
- `flush`  out  1  kill all in-flight younger instructions
- `busy`  out  1  controller not idle; gates writeback `prev_valid` upstream

## Operation
- FSM states: IDLE, FLUSH, REDIR. `busy` = (state != IDLE).
- IDLE transitions:
  - If `trap_valid`: latch `trap_vec` into `redir_pc`, pulse `trap_ack`, load `cnt` = FLUSH_CYCLES-1, go to FLUSH.
  - Else if `wb_valid & wb_change`: latch `wb_npc`, load `cnt`, go to FLUSH.
  - Else stay in IDLE.
- Simultaneous trap and branch requests: the trap wins. The branch request is dropped, because the flush kills it.
- FLUSH: `flush`=1. If `cnt`==0, go to REDIR; else decrement `cnt`. `cnt` is 4 bits.
- REDIR: `redir_valid`=1 with `redir_pc` held. When `redir_valid & ifu_ready` at a rising edge, go to IDLE. A redirect with `ifu_ready` low waits indefinitely.
- Requests arriving while not in IDLE:
  - `trap_valid` is not acked and stays pending at the source. It is accepted in the first IDLE cycle.
  - `wb_valid` while busy is a protocol violation and is ignored.
- All outputs are decoded from registered state only, with no combinational input-to-output paths.
- Reset values: state=IDLE, `cnt`=0, `redir_pc`=0, `flush`=0, `redir_valid`=0, `trap_ack`=0, `busy`=0.
- Reset asserted mid-sequence returns to IDLE on the next edge and drops any latched redirect; no redirect is issued.

## Timing
- Request sampled at edge t: `flush` high for cycles t+1 .. t+FLUSH_CYCLES.
- `redir_valid` rises at t+FLUSH_CYCLES+1.
- With `ifu_ready` held high, the handshake completes at that edge, `busy` drops one cycle later, and a new request can be accepted in that IDLE cycle.
- Minimum request-to-request spacing: FLUSH_CYCLES+2 cycles.
- `trap_ack` is high during cycle t+1 only.

## Configuration
- `YSYX_REDIRECT_PERF_EN` defined: adds 32-bit outputs `perf_commit`, `perf_mispredict`, `perf_branch_ok` and `perf_trap`, all reset to 0 and wrapping modulo 2^32.
  - `perf_commit` increments on each `wb_valid`.
  - `perf_mispredict` increments on each accepted branch redirect.
  - `perf_branch_ok` increments on `wb_valid & wb_retire`.
  - `perf_trap` increments on each `trap_ack`.
- Undefined: those ports and their counters do not exist. Functional behaviour is identical in both builds.

## Test plan
- Branch redirect, FLUSH_CYCLES=2: `wb_valid`=`wb_change`=1, `wb_npc`=0x8000_0100, `ifu_ready`=1 → `flush` high 2 cycles, then `redir_valid`=1 with `redir_pc`=0x8000_0100 for 1 cycle, then IDLE.
- Simultaneous branch (npc 0x8000_0200) and trap (vec 0x8000_0004) in IDLE → single `trap_ack` pulse, `redir_pc`=0x8000_0004, no second redirect.
- IFU backpressure: `ifu_ready`=0 for 5 cycles in REDIR → `redir_valid` and `redir_pc` stable for 6 cycles; handshake on the 6th; `busy` low on the next cycle.
- Trap raised during FLUSH → no ack until IDLE; accepted in the IDLE cycle right after the first redirect; back-to-back spacing FLUSH_CYCLES+2.
- Reset asserted in FLUSH → next cycle all outputs are at reset values; `redir_valid` is never asserted.
- With `YSYX_REDIRECT_PERF_EN`: 10 commits, including 3 mispredicts, 4 good branches and 1 trap → counters read 10/3/4/1. Preload `perf_commit` to 0xFFFF_FFFF via force and commit once → wraps to 0.
